// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: datapath width, reset vector and the fetch-entry record.
package rv32i_pkg;

    localparam int unsigned WIDTH = 32;
    localparam logic [WIDTH-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [WIDTH-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {instr, pc} entries with flush; Depth must be a power of two.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            push_i,
    input  fetch_entry_t    push_data_i,
    input  logic            pop_i,
    output logic [CntW-1:0] count_o,
    output fetch_entry_t    head_o
);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + 1'b1;
            if (pop_i)  rptr_d = rptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !flush_i && push_i) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, one-cycle ROM reads, prefetch buffering and redirect flush.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned      AddrWidth = 8,
    parameter int unsigned      Depth     = 4,
    parameter logic [WIDTH-1:0] ResetPc   = RESET_PC
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 imem_req_o,
    output logic [AddrWidth-1:0] imem_addr_o,
    input  logic [WIDTH-1:0]     imem_rdata_i,
    input  logic                 redirect_i,
    input  logic [WIDTH-1:0]     redirect_target_i,
    output logic                 instr_valid_o,
    output logic [WIDTH-1:0]     instr_o,
    output logic [WIDTH-1:0]     instr_pc_o,
    input  logic                 instr_ready_i
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [CntW:0] DepthOcc = (CntW + 1)'(Depth);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] pending_pc_q, pending_pc_d;
    logic             pending_q, pending_d;

    logic [CntW-1:0]  count;
    logic [CntW:0]    occupancy;
    logic             issue, push, pop, has_entry;
    fetch_entry_t     head, push_entry;

    // Reserve a slot for the in-flight read so a response can never overflow the buffer.
    assign occupancy  = {1'b0, count} + {{CntW{1'b0}}, pending_q};
    assign issue      = rst_ni & ~redirect_i & (occupancy < DepthOcc);
    assign push       = pending_q & ~redirect_i;
    assign has_entry  = rst_ni & (count != '0);
    assign pop        = instr_valid_o & instr_ready_i;
    assign push_entry = '{instr: imem_rdata_i, pc: pending_pc_q};

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        pending_d    = 1'b0;
        if (redirect_i) begin
            fetch_pc_d = {redirect_target_i[WIDTH-1:2], 2'b00};
        end else if (issue) begin
            pending_d    = 1'b1;
            pending_pc_d = fetch_pc_q;
            fetch_pc_d   = fetch_pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_pc_q   <= ResetPc;
            pending_pc_q <= '0;
            pending_q    <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            pending_q    <= pending_d;
        end
    end

    fetch_fifo #(
        .Depth(Depth)
    ) u_fetch_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (redirect_i),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .count_o    (count),
        .head_o     (head)
    );

    assign imem_req_o    = issue;
    assign imem_addr_o   = fetch_pc_q[AddrWidth-1:0];
    assign instr_valid_o = has_entry & ~redirect_i;
    assign instr_o       = has_entry ? head.instr : '0;
    assign instr_pc_o    = has_entry ? head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, plus directed literal checks.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int errors = 0;
    int checks = 0;

    fetch_unit #(
        .AddrWidth(8),
        .Depth    (DEPTH),
        .ResetPc  (RST_PC)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_rdata_i     (imem_rdata),
        .redirect_i       (redirect),
        .redirect_target_i(redirect_target),
        .instr_valid_o    (instr_valid),
        .instr_o          (instr),
        .instr_pc_o       (instr_pc),
        .instr_ready_i    (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [7:0] a);
        return 32'h0010_0093 + 32'(a >> 2);
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= rom(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered words as a queue, one optional in-flight read, a fetch PC.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    int          m_pend = 0;
    logic [31:0] m_pend_pc = '0;
    logic [31:0] m_pc = '0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        bit do_issue;
        if (!rst_n) begin
            started = 1'b1;
            mq.delete();
            m_pend = 0;
            m_pc = RST_PC;
        end else if (redirect) begin
            mq.delete();
            m_pend = 0;
            m_pc = redirect_target & ~32'h3;
        end else begin
            do_issue = (mq.size() + m_pend) < DEPTH;
            if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
            if (m_pend != 0) mq.push_back('{instr: rom(m_pend_pc[7:0]), pc: m_pend_pc});
            if (do_issue) begin
                m_pend = 1;
                m_pend_pc = m_pc;
                m_pc = m_pc + 32'd4;
            end else begin
                m_pend = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic        e_req, e_valid;
        logic [31:0] e_instr, e_pc;
        if (started) begin
            e_req   = rst_n && !redirect && ((mq.size() + m_pend) < DEPTH);
            e_valid = rst_n && !redirect && (mq.size() > 0);
            e_instr = '0;
            e_pc    = '0;
            if (rst_n && mq.size() > 0) begin
                e_instr = mq[0].instr;
                e_pc    = mq[0].pc;
            end
            chk("model imem_req", {31'b0, imem_req}, {31'b0, e_req});
            chk("model imem_addr", {24'b0, imem_addr}, {24'b0, m_pc[7:0]});
            chk("model instr_valid", {31'b0, instr_valid}, {31'b0, e_valid});
            chk("model instr", instr, e_instr);
            chk("model instr_pc", instr_pc, e_pc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;
        instr_ready = 1'b1;
        repeat (2) step();

        // Reset release, streaming with ready high
        rst_n = 1'b1;
        @(negedge clk);
        chk("c0 imem_req", {31'b0, imem_req}, 32'd1);
        chk("c0 imem_addr", {24'b0, imem_addr}, 32'h0);
        chk("c0 instr_valid", {31'b0, instr_valid}, 32'd0);
        step(); @(negedge clk);
        chk("c1 instr_valid", {31'b0, instr_valid}, 32'd0);
        step(); @(negedge clk);
        chk("c2 instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("c2 instr_pc", instr_pc, 32'h0);
        chk("c2 instr", instr, 32'h0010_0093);
        for (int i = 1; i < 4; i++) begin
            step(); @(negedge clk);
            chk("stream valid", {31'b0, instr_valid}, 32'd1);
            chk("stream pc", instr_pc, 32'(4 * i));
        end

        // Backpressure: fill and stall, then drain in order
        instr_ready = 1'b0;
        do_reset();
        repeat (10) step();
        @(negedge clk);
        chk("full imem_req", {31'b0, imem_req}, 32'd0);
        chk("full imem_addr", {24'b0, imem_addr}, 32'h10);
        chk("full head pc", instr_pc, 32'h0);
        step();
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drain valid", {31'b0, instr_valid}, 32'd1);
            chk("drain pc", instr_pc, 32'(4 * i));
            step();
        end

        // Redirect to 0x23 with pending=1 and two entries buffered
        instr_ready = 1'b0;
        do_reset();
        repeat (3) step();
        redirect = 1'b1;
        redirect_target = 32'h23;
        @(negedge clk);
        chk("redir instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("redir imem_req", {31'b0, imem_req}, 32'd0);
        step();
        redirect = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("redir+1 imem_req", {31'b0, imem_req}, 32'd1);
        chk("redir+1 imem_addr", {24'b0, imem_addr}, 32'h20);
        chk("redir+1 instr_valid", {31'b0, instr_valid}, 32'd0);
        step(); @(negedge clk);
        chk("redir+2 instr_valid", {31'b0, instr_valid}, 32'd0);
        step(); @(negedge clk);
        chk("redir+3 instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("redir+3 instr_pc", instr_pc, 32'h20);
        chk("redir+3 instr", instr, 32'h0010_009B);
        step(); @(negedge clk);
        chk("redir+4 instr_pc", instr_pc, 32'h24);

        // ROM address wraps while the PC keeps counting
        redirect = 1'b1;
        redirect_target = 32'hF8;
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("wrap addr0", {24'b0, imem_addr}, 32'hF8);
        step(); @(negedge clk);
        chk("wrap addr1", {24'b0, imem_addr}, 32'hFC);
        step(); @(negedge clk);
        chk("wrap addr2", {24'b0, imem_addr}, 32'h00);
        chk("wrap pc0", instr_pc, 32'hF8);
        step(); @(negedge clk);
        chk("wrap pc1", instr_pc, 32'hFC);
        step(); @(negedge clk);
        chk("wrap pc2", instr_pc, 32'h100);
        chk("wrap instr2", instr, 32'h0010_0093);

        // Reset mid-stream with three entries buffered
        instr_ready = 1'b0;
        do_reset();
        repeat (4) step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("midrst imem_req", {31'b0, imem_req}, 32'd0);
        chk("midrst instr", instr, 32'h0);
        step();
        rst_n = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("postrst instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("postrst imem_addr", {24'b0, imem_addr}, 32'h0);
        chk("postrst imem_req", {31'b0, imem_req}, 32'd1);
        step(); step(); @(negedge clk);
        chk("postrst+2 instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("postrst+2 instr_pc", instr_pc, 32'h0);

        // Randomized traffic; the per-cycle model compare does the checking
        for (int n = 0; n < 3000; n++) begin
            step();
            rst_n = ($urandom_range(0, 99) != 0);
            redirect = ($urandom_range(0, 19) == 0);
            redirect_target = $urandom;
            instr_ready = ($urandom_range(0, 3) != 0);
        end
        step();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
